lcm_div: RTL and testbench

LCM_DIV -- requirements
Module: lcm_div

---
 rtl/lcm_div_if.sv | 26 ++
 rtl/lcm_div.sv | 97 +++++++++
 tb/tb_lcm_div.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/lcm_div_if.sv
// Request/result bundle for lcm_div: operands and start in, quotients,
// remainders and status out.
interface lcm_div_if;
  logic       go_i;
  logic [7:0] l_i;
  logic [7:0] x_i;
  logic [7:0] y_i;
  logic [7:0] qx_o;
  logic [7:0] rx_o;
  logic [7:0] qy_o;
  logic [7:0] ry_o;
  logic       ok_o;
  logic       err_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output go_i, l_i, x_i, y_i,
    input  qx_o, rx_o, qy_o, ry_o, ok_o, err_o, busy_o, done_o
  );

  modport slave (
    input  go_i, l_i, x_i, y_i,
    output qx_o, rx_o, qy_o, ry_o, ok_o, err_o, busy_o, done_o
  );
endinterface

// File: rtl/lcm_div.sv
// Divides one candidate common multiple by two divisors using repeated
// subtraction, reporting both quotients/remainders and whether both divide.
module lcm_div (
  input  logic      clk,
  input  logic      rst,
  lcm_div_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SUBX, SUBY, DONE} state_t;

  state_t     state;
  logic [7:0] acc;
  logic [7:0] l_r;
  logic [7:0] x_r;
  logic [7:0] y_r;
  logic [7:0] qx;
  logic [7:0] rx;
  logic [7:0] qy;
  logic [7:0] ry;
  logic       err;
  logic       ok;

  // NOTE: every register here is written with <= so that all of them see
  // the pre-edge values of acc/qx/qy within the same clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      l_r   <= '0;
      x_r   <= '0;
      y_r   <= '0;
      qx    <= '0;
      rx    <= '0;
      qy    <= '0;
      ry    <= '0;
      err   <= 1'b0;
      ok    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.go_i) begin
            l_r <= bus.l_i;
            x_r <= bus.x_i;
            y_r <= bus.y_i;
            acc <= bus.l_i;
            qx  <= '0;
            rx  <= '0;
            qy  <= '0;
            ry  <= '0;
            ok  <= 1'b0;
            // A zero divisor skips the subtraction loops entirely.
            if (bus.x_i == 8'd0 || bus.y_i == 8'd0) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              state <= SUBX;
            end
          end
        end
        SUBX: begin
          if (acc >= x_r) begin
            acc <= acc - x_r;
            qx  <= qx + 8'd1;
          end else begin
            rx    <= acc;
            acc   <= l_r;
            state <= SUBY;
          end
        end
        SUBY: begin
          if (acc >= y_r) begin
            acc <= acc - y_r;
            qy  <= qy + 8'd1;
          end else begin
            ry    <= acc;
            // rx is already final here; acc is the remainder being stored.
            ok    <= (rx == 8'd0) && (acc == 8'd0);
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.qx_o   = qx;
  assign bus.rx_o   = rx;
  assign bus.qy_o   = qy;
  assign bus.ry_o   = ry;
  assign bus.err_o  = err;
  assign bus.ok_o   = ok;
  assign bus.busy_o = (state != IDLE);
  assign bus.done_o = (state == DONE);

endmodule

// File: tb/tb_lcm_div.sv
// Directed-vector bench for lcm_div with hand-computed quotients, remainders
// and completion latencies.
module tb_lcm_div;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lcm_div_if bus ();

  lcm_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] qx, input logic [7:0] rx,
                               input logic [7:0] qy, input logic [7:0] ry,
                               input logic ok, input logic err);
    check({tag, "_qx"},  bus.qx_o,  qx);
    check({tag, "_rx"},  bus.rx_o,  rx);
    check({tag, "_qy"},  bus.qy_o,  qy);
    check({tag, "_ry"},  bus.ry_o,  ry);
    check({tag, "_ok"},  bus.ok_o,  ok);
    check({tag, "_err"}, bus.err_o, err);
  endtask

  // Pulses go_i for one capture edge; returns #1 after that edge.
  task automatic start(input logic [7:0] l, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    bus.go_i = 1'b1;
    bus.l_i  = l;
    bus.x_i  = x;
    bus.y_i  = y;
    @(posedge clk);
    #1;
    bus.go_i = 1'b0;
  endtask

  // Counts edges after capture until done_o is seen; optionally scrambles
  // go_i and the operands while the operation is in flight.
  task automatic wait_done(input bit perturb, output int edges);
    edges = 0;
    while (!bus.done_o && edges < 600) begin
      if (perturb) begin
        bus.go_i = edges[0];
        bus.l_i  = 8'(edges * 7 + 1);
        bus.x_i  = 8'd0;
        bus.y_i  = 8'(edges);
      end
      @(posedge clk);
      #1;
      edges++;
    end
    bus.go_i = 1'b0;
    check("done_seen", bus.done_o, 1'b1);
  endtask

  task automatic run_case(input string tag, input logic [7:0] l, input logic [7:0] x,
                          input logic [7:0] y, input int lat,
                          input logic [7:0] qx, input logic [7:0] rx,
                          input logic [7:0] qy, input logic [7:0] ry,
                          input logic ok, input logic err, input bit perturb);
    int edges;
    start(l, x, y);
    wait_done(perturb, edges);
    check({tag, "_lat"}, edges, lat);
    check_outputs(tag, qx, rx, qy, ry, ok, err);
    @(posedge clk);
    #1;
    check({tag, "_idle_busy"}, bus.busy_o, 1'b0);
    check({tag, "_idle_done"}, bus.done_o, 1'b0);
    check_outputs({tag, "_hold"}, qx, rx, qy, ry, ok, err);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int edges;
    int done_cnt;

    rst      = 1'b1;
    bus.go_i = 1'b0;
    bus.l_i  = 8'd0;
    bus.x_i  = 8'd0;
    bus.y_i  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_done", bus.done_o, 1'b0);
    check_outputs("rst", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);

    // go_i is raised for the very first edge with rst low.
    rst = 1'b0;
    run_case("lcm36",  8'd36,  8'd12, 8'd18, 7,   8'd3,   8'd0, 8'd2, 8'd0, 1'b1, 1'b0, 1'b0);
    run_case("n37",    8'd37,  8'd12, 8'd18, 7,   8'd3,   8'd1, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0);
    // The error path enters DONE on the capture edge itself, so done_o is
    // already high right after capture and busy_o lasts one cycle.
    run_case("x0",     8'd50,  8'd0,  8'd5,  0,   8'd0,   8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    run_case("max",    8'd255, 8'd1,  8'd255, 258, 8'd255, 8'd0, 8'd1, 8'd0, 1'b1, 1'b0, 1'b0);
    run_case("small",  8'd5,   8'd7,  8'd9,  2,   8'd0,   8'd5, 8'd0, 8'd5, 1'b0, 1'b0, 1'b0);
    run_case("y0",     8'd10,  8'd3,  8'd0,  0,   8'd0,   8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    run_case("pert",   8'd36,  8'd12, 8'd18, 7,   8'd3,   8'd0, 8'd2, 8'd0, 1'b1, 1'b0, 1'b1);

    // go_i held high across DONE: re-accepted at the first IDLE edge.
    @(negedge clk);
    bus.go_i = 1'b1;
    bus.l_i  = 8'd36;
    bus.x_i  = 8'd12;
    bus.y_i  = 8'd18;
    @(posedge clk);
    #1;
    edges = 0;
    while (!bus.done_o && edges < 600) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("hold_lat", edges, 7);
    bus.l_i = 8'd5;
    bus.x_i = 8'd7;
    bus.y_i = 8'd9;
    @(posedge clk);
    #1;
    check("hold_idle_busy", bus.busy_o, 1'b0);
    @(posedge clk);
    #1;
    check("hold_regrab_busy", bus.busy_o, 1'b1);
    wait_done(1'b0, edges);
    check("hold_regrab_lat", edges, 2);
    check_outputs("hold_regrab", 8'd0, 8'd5, 8'd0, 8'd5, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Abort an operation mid-SUBX with rst while scrambling inputs.
    start(8'd100, 8'd3, 8'd4);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.go_i = i[0];
      bus.l_i  = 8'(i * 13);
      bus.x_i  = 8'(i);
      bus.y_i  = 8'd1;
      @(posedge clk);
      #1;
      if (bus.done_o) done_cnt++;
    end
    check("abort_mid_busy", bus.busy_o, 1'b1);
    check("abort_mid_qx", bus.qx_o, 8'd10);
    bus.go_i = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", bus.busy_o, 1'b0);
    check("abort_done", bus.done_o, 1'b0);
    check_outputs("abort", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    run_case("after", 8'd36, 8'd12, 8'd18, 7, 8'd3, 8'd0, 8'd2, 8'd0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
